// File: rtl/arm_position_writer.sv
// Write side of the arm position RAM: appends operator-entered positions at sequential
// addresses, zero-fills the RAM on a clear request, and exports fill/overflow status.
module arm_position_writer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned MEM_DEPTH     = 2 ** ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req,
    input  logic                     clr_req,
    input  logic [DATA_WIDTH-1:0]    position,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2,
        FULL  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic [CW-1:0]            clr_addr_q, clr_addr_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        clr_addr_d  = clr_addr_q;

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end else if (wr_req) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_q[ADDRESS_WIDTH-1:0];
                    mem_wdata_d = position;
                    count_d     = count_q + CW'(1);
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                state_d = (count_q == DEPTH) ? FULL : IDLE;
            end
            CLEAR: begin
                // Sweep one address per cycle; the extra counter bit marks sweep completion
                if (clr_addr_q == DEPTH) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = clr_addr_q[ADDRESS_WIDTH-1:0];
                    mem_wdata_d = '0;
                    clr_addr_d  = clr_addr_q + CW'(1);
                end
            end
            FULL: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end else if (wr_req) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            clr_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            clr_addr_q  <= clr_addr_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign full      = (count_q == DEPTH);
    assign busy      = (state_q == WRITE) || (state_q == CLEAR);

endmodule

// File: tb/tb_arm_position_writer.sv
// Scoreboard bench for arm_position_writer with a 4-word memory (3-bit address).
module tb_arm_position_writer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned MD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic          clr_req;
    logic [DW-1:0] position;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;
    logic          busy;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    arm_position_writer #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MEM_DEPTH     (MD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .clr_req   (clr_req),
        .position  (position),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every RAM write the DUT presents must match the head of the queue
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(w.addr));
                check("write_data", 32'(mem_wdata), 32'(w.data));
            end
        end
    end

    task automatic pulse_wr(input logic [DW-1:0] pos);
        @(negedge clk);
        wr_req   = 1'b1;
        position = pos;
        @(negedge clk);
        wr_req   = 1'b0;
        position = 16'hDEAD;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected end before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int we_cnt;
        rst      = 1'b0;
        wr_req   = 1'b0;
        clr_req  = 1'b0;
        position = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Single write: one-cycle we pulse, position sampled only on the accept edge
        push(0, 16'h1234);
        pulse_wr(16'h1234);
        check("t1_we", 32'(mem_we), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_we_low", 32'(mem_we), 32'd0);
        check("t1_wdata_held", 32'(mem_wdata), 32'h1234);
        check("t1_busy_low", 32'(busy), 32'd0);

        // Three spaced writes from a fresh reset
        do_reset();
        push(0, 16'h0005); pulse_wr(16'h0005); @(negedge clk);
        push(1, 16'hFFFF); pulse_wr(16'hFFFF); @(negedge clk);
        push(2, 16'h0100); pulse_wr(16'h0100); @(negedge clk);
        check("t2_count", 32'(count), 32'd3);
        check("t2_full", 32'(full), 32'd0);

        // Fourth write fills; fifth overflows
        push(3, 16'h0A0A);
        pulse_wr(16'h0A0A);
        check("t3_we", 32'(mem_we), 32'd1);
        check("t3_full_with_we", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd4);
        @(negedge clk);
        pulse_wr(16'hBEEF);
        check("t3_no_we", 32'(mem_we), 32'd0);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_count_held", 32'(count), 32'd4);
        check("t3_full_held", 32'(full), 32'd1);

        // Clear from FULL: four zero writes at 0..3 while busy
        for (int a = 0; a < 4; a++) push(a, 16'h0000);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        check("t4_busy", 32'(busy), 32'd1);
        we_cnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (mem_we) we_cnt++;
            @(negedge clk);
        end
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_we_cycles", 32'(we_cnt), 32'd4);
        check("t4_count", 32'(count), 32'd0);
        check("t4_full", 32'(full), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous wr+clr: clear wins; wr during sweep ignored
        for (int a = 0; a < 4; a++) push(a, 16'h0000);
        @(negedge clk);
        wr_req   = 1'b1;
        clr_req  = 1'b1;
        position = 16'h5555;
        @(negedge clk);
        wr_req   = 1'b0;
        clr_req  = 1'b0;
        @(negedge clk);
        pulse_wr(16'h6666);
        wait_idle("t5_idle");
        @(negedge clk);
        check("t5_count", 32'(count), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Async reset in the middle of a clear sweep
        push(0, 16'h7777);
        pulse_wr(16'h7777);
        @(negedge clk);
        check("t6_count_pre", 32'(count), 32'd1);
        push(0, 16'h0000);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < 10 && !mem_we; i++) @(negedge clk);
        check("t6_sweep_started", 32'(mem_we), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("t6_abort_we", 32'(mem_we), 32'd0);
        check("t6_abort_count", 32'(count), 32'd0);
        check("t6_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push(0, 16'h00AB);
        pulse_wr(16'h00AB);
        check("t6_addr0", 32'(mem_addr), 32'd0);
        check("t6_count", 32'(count), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
